// File: rtl/uart_add_sequencer.sv
// uart_add_sequencer: adds two bytes from uart_rx and sends the carry byte, then the sum byte, through uart_tx
module uart_add_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT_CLKS = 17480
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [DATA_WIDTH-1:0] i_Rx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done,
    output logic                  o_Tx_DV,
    output logic [DATA_WIDTH-1:0] o_Tx_Byte,
    output logic                  o_Busy,
    output logic                  o_Timeout,
    output logic                  o_Overrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_B, S_CALC, S_SEND_HI, S_WAIT_HI, S_GAP, S_SEND_LO, S_WAIT_LO
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a, b;
    logic [DATA_WIDTH:0]   sum;
    logic [31:0]           cnt;
    logic                  tx_idle;

    assign tx_idle = !i_Tx_Active && !i_Tx_Done;

    // Operand capture with inter-byte timeout, then a paced carry/sum send; bytes arriving after B are dropped and flagged
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            a         <= '0;
            b         <= '0;
            sum       <= '0;
            cnt       <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            o_Busy    <= 1'b0;
            o_Timeout <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            o_Tx_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            o_Overrun <= i_Rx_DV && !(state inside {S_IDLE, S_WAIT_B});
            case (state)
                S_IDLE:
                    if (i_Rx_DV) begin
                        a      <= i_Rx_Byte;
                        cnt    <= '0;
                        o_Busy <= 1'b1;
                        state  <= S_WAIT_B;
                    end
                S_WAIT_B:
                    if (i_Rx_DV) begin
                        b     <= i_Rx_Byte;
                        state <= S_CALC;
                    end else if (cnt == 32'(TIMEOUT_CLKS - 2)) begin
                        o_Timeout <= 1'b1;
                        o_Busy    <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                S_CALC: begin
                    sum   <= {1'b0, a} + {1'b0, b};
                    state <= S_SEND_HI;
                end
                S_SEND_HI:
                    if (tx_idle) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH]};
                        state     <= S_WAIT_HI;
                    end
                S_WAIT_HI:
                    if (i_Tx_Done) state <= S_GAP;
                S_GAP:
                    if (!i_Tx_Done) state <= S_SEND_LO;
                S_SEND_LO:
                    if (tx_idle) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= sum[DATA_WIDTH-1:0];
                        state     <= S_WAIT_LO;
                    end
                S_WAIT_LO:
                    if (i_Tx_Done) begin
                        o_Busy <= 1'b0;
                        state  <= S_IDLE;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_add_sequencer.sv
// tb_uart_add_sequencer: directed scenarios against a timeline model of the adder sequencer and a uart_tx stand-in
module tb_uart_add_sequencer;
    localparam int T  = 40;
    localparam int FR = 12;

    logic       i_Clock = 1'b0, i_Reset = 1'b1, i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       i_Tx_Active, i_Tx_Done;
    logic       o_Tx_DV, o_Busy, o_Timeout, o_Overrun;
    logic [7:0] o_Tx_Byte;

    int checks = 0, errors = 0, cyc = 0;
    bit started = 0;

    uart_add_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CLKS(T)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
        .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
        .o_Busy(o_Busy), .o_Timeout(o_Timeout), .o_Overrun(o_Overrun)
    );

    always #5 i_Clock = ~i_Clock;

    // cycle c ends at posedge number c
    always @(posedge i_Clock) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // uart_tx stand-in: FR cycles active, then Done for 2 cycles; DV ignored while busy
    int   em_cnt = 0;
    logic em_act = 1'b0, em_done = 1'b0, hold_act = 1'b0;
    int   fall_t[$];
    assign i_Tx_Active = em_act | hold_act;
    assign i_Tx_Done   = em_done;
    always @(negedge i_Clock) begin
        if (em_cnt > 0) em_cnt--;
        else if (o_Tx_DV === 1'b1) em_cnt = FR + 2;
        em_act = em_cnt > 2;
        if (em_done && !(em_cnt inside {1, 2})) fall_t.push_back(cyc + 1);
        em_done = em_cnt inside {1, 2};
    end

    // timeline model: expected outputs for the cycle following each sampled edge
    logic       s_rst, s_rx, s_act, s_done;
    logic [7:0] s_byte;
    logic       e_dv = 0, e_to = 0, e_ov = 0, e_busy = 0;
    logic [7:0] e_byte = 0;
    bit         post_b = 0;

    task automatic step();
        @(posedge i_Clock);
        s_rst = i_Reset; s_rx = i_Rx_DV; s_byte = i_Rx_Byte; s_act = i_Tx_Active; s_done = i_Tx_Done;
        e_dv = 0; e_to = 0; e_ov = post_b && s_rx;
        if (s_rst) begin
            e_ov = 0; e_busy = 0; e_byte = 0; post_b = 0;
        end
    endtask

    task automatic run_op();
        logic [7:0] a;
        logic [8:0] sum;
        do step(); while (!s_rx || s_rst);
        a = s_byte;
        e_busy = 1;
        for (int i = 1; i < T; i++) begin
            step();
            if (s_rst) return;
            if (s_rx) break;
            if (i == T - 1) begin
                e_to = 1; e_busy = 0;
                return;
            end
        end
        sum = {1'b0, a} + {1'b0, s_byte};
        post_b = 1;
        step();
        if (s_rst) return;
        do begin step(); if (s_rst) return; end while (s_act || s_done);
        e_dv = 1; e_byte = {7'b0, sum[8]};
        do begin step(); if (s_rst) return; end while (!s_done);
        do begin step(); if (s_rst) return; end while (s_done);
        do begin step(); if (s_rst) return; end while (s_act || s_done);
        e_dv = 1; e_byte = sum[7:0];
        do begin step(); if (s_rst) return; end while (!s_done);
        e_busy = 0; post_b = 0;
    endtask

    initial forever run_op();

    // per-cycle compare against the model, plus event recording for the directed checks
    int         dv_t[$], to_t[$], ov_t[$];
    logic [7:0] dv_b[$];
    always @(negedge i_Clock) if (started) begin
        if (o_Tx_DV === 1'b1) begin dv_t.push_back(cyc + 1); dv_b.push_back(o_Tx_Byte); end
        if (o_Timeout === 1'b1) to_t.push_back(cyc + 1);
        if (o_Overrun === 1'b1) ov_t.push_back(cyc + 1);
        chk("m_tx_dv", o_Tx_DV, e_dv);
        chk("m_tx_byte", o_Tx_Byte, e_byte);
        chk("m_busy", o_Busy, e_busy);
        chk("m_timeout", o_Timeout, e_to);
        chk("m_overrun", o_Overrun, e_ov);
    end

    int rx_t;

    task automatic tick();
        @(negedge i_Clock);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic send_rx(logic [7:0] b);
        i_Rx_DV = 1'b1; i_Rx_Byte = b; rx_t = cyc + 1;
        tick();
        i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00;
    endtask

    task automatic send_at(logic [7:0] b, int c);
        while (cyc + 1 < c) tick();
        send_rx(b);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 3000 && (o_Busy || em_cnt != 0); i++) tick();
        chk("quiet_busy", o_Busy, 0);
        chk("quiet_tx", em_cnt, 0);
    endtask

    task automatic wait_dv(int n);
        for (int i = 0; i < 500 && dv_t.size() < n; i++) tick();
        chk("dv_wait", dv_t.size(), n);
    endtask

    task automatic expect_bytes(string nm, int base, logic [7:0] hi, logic [7:0] lo);
        chk({nm, "_count"}, dv_t.size(), base + 2);
        if (dv_t.size() >= base + 2) begin
            chk({nm, "_hi"}, dv_b[base], hi);
            chk({nm, "_lo"}, dv_b[base + 1], lo);
        end
    endtask

    task automatic add_pair(string nm, logic [7:0] x, logic [7:0] y, logic [7:0] hi, logic [7:0] lo);
        int base;
        base = dv_t.size();
        send_rx(x); idle(2); send_rx(y);
        wait_quiet();
        expect_bytes(nm, base, hi, lo);
    endtask

    initial begin
        int base, fb, a, f, tb_b;
        idle(3);
        chk("rst_dv", o_Tx_DV, 0);
        chk("rst_byte", o_Tx_Byte, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_to", o_Timeout, 0);
        chk("rst_ov", o_Overrun, 0);
        i_Reset = 1'b0;
        idle(2);

        base = dv_t.size();
        send_rx(8'h12); idle(2); send_rx(8'h34); tb_b = rx_t;
        wait_quiet();
        expect_bytes("basic", base, 8'h00, 8'h46);
        if (dv_t.size() > base) chk("basic_lat", dv_t[base] - tb_b, 3);

        base = dv_t.size(); fb = fall_t.size();
        send_rx(8'hFF); send_rx(8'hFF);
        wait_quiet();
        expect_bytes("carry", base, 8'h01, 8'hFE);
        if (dv_t.size() >= base + 2 && fall_t.size() > fb) chk("carry_gap", dv_t[base + 1] - fall_t[fb], 2);

        base = dv_t.size();
        send_rx(8'h05); a = rx_t;
        idle(T + 5);
        chk("to_count", to_t.size(), 1);
        if (to_t.size() > 0) chk("to_time", to_t[0] - a, T);
        chk("to_no_dv", dv_t.size(), base);
        add_pair("after_to", 8'h01, 8'h02, 8'h00, 8'h03);

        base = dv_t.size();
        send_rx(8'h40); a = rx_t;
        send_at(8'h02, a + T - 1);
        wait_quiet();
        chk("expiry_no_to", to_t.size(), 1);
        expect_bytes("expiry", base, 8'h00, 8'h42);

        base = dv_t.size();
        send_rx(8'h10); send_rx(8'h20);
        wait_dv(base + 1);
        idle(3);
        send_rx(8'h99); a = rx_t;
        wait_quiet();
        chk("ov_count", ov_t.size(), 1);
        if (ov_t.size() > 0) chk("ov_time", ov_t[0] - a, 1);
        expect_bytes("ov", base, 8'h00, 8'h30);
        add_pair("after_ov", 8'h01, 8'h01, 8'h00, 8'h02);

        base = dv_t.size();
        hold_act = 1'b1;
        send_rx(8'h80); send_rx(8'h85);
        idle(50);
        chk("gate_early", dv_t.size(), base);
        hold_act = 1'b0; f = cyc + 1;
        wait_quiet();
        expect_bytes("gate", base, 8'h01, 8'h05);
        if (dv_t.size() > base) chk("gate_lat", dv_t[base] - f, 1);

        base = dv_t.size();
        send_rx(8'h55); send_rx(8'h66);
        wait_dv(base + 1);
        idle(2);
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        chk("mrst_dv", o_Tx_DV, 0);
        chk("mrst_byte", o_Tx_Byte, 0);
        chk("mrst_busy", o_Busy, 0);
        fb = fall_t.size(); base = dv_t.size();
        send_rx(8'h7F); send_rx(8'h01);
        wait_quiet();
        expect_bytes("mrst", base, 8'h00, 8'h80);
        if (dv_t.size() > base && fall_t.size() > fb) chk("mrst_wait", dv_t[base] - fall_t[fb], 1);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
